// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the bus between the fetch port, the load/store port,
// the memory and the arbiter that shares the memory between them.
//   if_*  : fetch requester (read only)
//   d_*   : load/store requester (read or write, byte mask on writes)
//   mem_* : single-port memory (mem_rdata returns RD_LAT cycles after a read)
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory's view
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MW = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MW-1:0]     d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MW-1:0]     mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between
// the instruction-fetch port and the load/store port. At most one access per
// grant; a read blocks further grants until its data returns RD_LAT cycles
// later, and the returned data is flagged valid only to the port that asked.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset; all outputs forced to 0 while low
//   bus   : mem_port_arbiter_if.slave (requesters + memory)
// Parameters: ADDR_W, DATA_W (multiple of 8), RD_LAT (1..7).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic { IDLE, RD_WAIT } state_t;
  typedef enum logic { PORT_IF, PORT_D } port_t;

  state_t     state, state_nxt;
  port_t      last_gnt, last_gnt_nxt;
  port_t      owner, owner_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pend, pend_nxt;  // read data returns this cycle
  logic       if_gnt, d_gnt, rd_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= PORT_D;   // so fetch wins the first contention
      owner    <= PORT_IF;
      cnt      <= '0;
      pend     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      owner    <= owner_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    pend_nxt     = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;

    // Grants are gated by reset so nothing leaks out while it is held low.
    if (reset && state == IDLE) begin
      if (bus.if_req && (!bus.d_req || last_gnt == PORT_D)) if_gnt = 1'b1;
      else if (bus.d_req)                                   d_gnt  = 1'b1;
    end
    rd_gnt = if_gnt || (d_gnt && !bus.d_we);

    case (state)
      IDLE: begin
        if (rd_gnt) begin
          owner_nxt = d_gnt ? PORT_D : PORT_IF;
          if (RD_LAT == 1) begin
            pend_nxt = 1'b1;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 3'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        // cnt counts down to 1 on the cycle before the return cycle
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (if_gnt || d_gnt) last_gnt_nxt = d_gnt ? PORT_D : PORT_IF;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt || d_gnt;
  assign bus.mem_we    = d_gnt && bus.d_we;
  assign bus.mem_addr  = if_gnt ? bus.if_addr : (d_gnt ? bus.d_addr : '0);
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
  assign bus.mem_wmask = d_gnt ? bus.d_wmask : '0;

  // rdata is a straight pass-through; rvalid alone says whose it is.
  assign bus.if_rvalid = reset && pend && owner == PORT_IF;
  assign bus.d_rvalid  = reset && pend && owner == PORT_D;
  assign bus.if_rdata  = reset ? bus.mem_rdata : '0;
  assign bus.d_rdata   = reset ? bus.mem_rdata : '0;
endmodule
